// File: rtl/sm510_ram_arbiter.sv
// Single-port SM510 data RAM arbiter: CPU > RTC sequencer > LCD scanner, fixed priority,
// plus the HMS time save/restore FSM that moves HHMMSS BCD across six RAM nibbles.
module sm510_ram_arbiter #(
    parameter int AW = 7,
    parameter logic [AW-1:0] LCD_BASE = 7'h60
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_tick,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_we,
    input  logic [3:0]    cpu_wdata,
    output logic [3:0]    cpu_rdata,
    input  logic          lcd_req,
    input  logic [4:0]    lcd_addr,
    output logic [3:0]    lcd_rdata,
    output logic          lcd_ack,
    input  logic          write_time,
    input  logic          read_time,
    input  logic [23:0]   hms_in,
    input  logic [AW-1:0] hms_loc,
    output logic [23:0]   hms_out,
    output logic          hms_rdy,
    output logic          busy,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [3:0]    ram_wdata,
    input  logic [3:0]    ram_rdata
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_LCD, OWN_RTC} own_t;

    state_t     state, state_n;
    own_t       own, owner_q;
    logic [2:0] idx, idx_n, rd_idx_q;
    logic       wt_q, rt_q, rd_tag_q;
    logic [3:0] cpu_hold, lcd_hold, wr_nib, hms_nib;
    logic [4:0] hms_sh;
    logic       wt_rise, rt_rise, start, rtc_go, pm;

    assign wt_rise = write_time & ~wt_q;
    assign rt_rise = read_time & ~rt_q;
    assign busy    = (state != IDLE);
    assign start   = (state == IDLE) && (wt_rise || rt_rise);
    // READ keeps the port one extra cycle (idx==6) while the last nibble comes back
    assign rtc_go  = (own == OWN_RTC) &&
                     ((state == WRITE) || (state == READ && idx < 3'd6));
    assign pm      = (hms_in[23:16] >= 8'h12);

    always_comb begin
        own = OWN_NONE;
        if (rst)          own = OWN_NONE;
        else if (cpu_tick) own = OWN_CPU;
        else if (busy)     own = OWN_RTC;
        else if (lcd_req)  own = OWN_LCD;
    end

    always_comb begin
        wr_nib = 4'h0;
        case (idx)
            3'd0:    wr_nib = {pm, hms_in[22:20]};
            3'd1:    wr_nib = hms_in[19:16];
            3'd2:    wr_nib = hms_in[15:12];
            3'd3:    wr_nib = hms_in[11:8];
            3'd4:    wr_nib = hms_in[7:4];
            3'd5:    wr_nib = hms_in[3:0];
            default: wr_nib = 4'h0;
        endcase
    end

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = 4'h0;
        case (own)
            OWN_CPU: begin
                ram_addr  = cpu_addr;
                ram_we    = cpu_we;
                ram_wdata = cpu_wdata;
            end
            OWN_LCD: ram_addr = LCD_BASE + AW'(lcd_addr);
            OWN_RTC: if (rtc_go) begin
                ram_addr  = hms_loc + AW'(idx);
                ram_we    = (state == WRITE);
                ram_wdata = wr_nib;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            IDLE: if (wt_rise) begin
                state_n = WRITE;
                idx_n   = 3'd0;
            end else if (rt_rise) begin
                state_n = READ;
                idx_n   = 3'd0;
            end
            WRITE: if (rtc_go) begin
                if (idx == 3'd5) state_n = DONE;
                else             idx_n   = idx + 3'd1;
            end
            READ: begin
                if (rtc_go) idx_n = idx + 3'd1;
                if (rd_tag_q && rd_idx_q == 3'd5) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // read data goes only to whoever owned the port last cycle; others hold
    assign cpu_rdata = (owner_q == OWN_CPU) ? ram_rdata : cpu_hold;
    assign lcd_rdata = (owner_q == OWN_LCD) ? ram_rdata : lcd_hold;
    assign lcd_ack   = (owner_q == OWN_LCD);
    assign hms_sh    = 5'd20 - {rd_idx_q, 2'b00};
    assign hms_nib   = (rd_idx_q == 3'd0) ? {1'b0, ram_rdata[2:0]} : ram_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 3'd0;
            wt_q     <= 1'b0;
            rt_q     <= 1'b0;
            owner_q  <= OWN_NONE;
            rd_tag_q <= 1'b0;
            rd_idx_q <= 3'd0;
            cpu_hold <= 4'h0;
            lcd_hold <= 4'h0;
            hms_out  <= 24'h0;
            hms_rdy  <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            wt_q     <= write_time;
            rt_q     <= read_time;
            owner_q  <= own;
            rd_tag_q <= rtc_go && (state == READ);
            rd_idx_q <= idx;
            cpu_hold <= cpu_rdata;
            lcd_hold <= lcd_rdata;
            if (start)
                hms_rdy <= 1'b0;
            else if (state_n == DONE && state != DONE)
                hms_rdy <= 1'b1;
            if (rd_tag_q)
                hms_out[hms_sh +: 4] <= hms_nib;
        end
    end
endmodule
